// File: rtl/individual_scorer.sv
// rtl/individual_scorer.sv - scores a candidate's outputs against expected vectors by matching-bit count
module individual_scorer #(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] vec_count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  y3,
  input  logic [W-1:0]  y2,
  input  logic [W-1:0]  y1,
  input  logic [W-1:0]  y0,
  input  logic [W-1:0]  e3,
  input  logic [W-1:0]  e2,
  input  logic [W-1:0]  e1,
  input  logic [W-1:0]  e0,
  output logic          busy,
  output logic          done,
  output logic [15:0]   score,
  output logic [CW-1:0] perfect_cnt
);

  localparam int NB = 4 * W;
  localparam int MW = $clog2(NB + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] vec_q;
  logic [CW-1:0] cnt;
  logic          s1_valid;
  logic [MW-1:0] s1_match;
  logic          s1_perfect;

  logic [NB-1:0] same;
  logic [MW-1:0] pop;
  logic          accept;
  logic [16:0]   sum;

  assign same   = ~({y3, y2, y1, y0} ^ {e3, e2, e1, e0});
  assign accept = in_valid && (state == RUN);
  assign busy   = (state == RUN) || (state == DRAIN);
  // Bit 16 of the widened sum flags overflow, which clamps the score.
  assign sum    = {1'b0, score} + 17'(s1_match);

  always_comb begin
    pop = '0;
    for (int i = 0; i < NB; i++) begin
      pop = pop + MW'(same[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      done        <= 1'b0;
      vec_q       <= '0;
      cnt         <= '0;
      s1_valid    <= 1'b0;
      s1_match    <= '0;
      s1_perfect  <= 1'b0;
      score       <= '0;
      perfect_cnt <= '0;
    end else begin
      done     <= 1'b0;
      s1_valid <= accept;
      if (accept) begin
        s1_match   <= pop;
        s1_perfect <= (pop == MW'(NB));
      end

      if (s1_valid) begin
        score <= sum[16] ? 16'hFFFF : sum[15:0];
        if (s1_perfect && (perfect_cnt != {CW{1'b1}})) begin
          perfect_cnt <= perfect_cnt + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            score       <= '0;
            perfect_cnt <= '0;
            cnt         <= '0;
            vec_q       <= vec_count;
            if (vec_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + CW'(1);
            if ((cnt + CW'(1)) == vec_q) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        // Stage 1 empty means stage 2 has taken the final beat.
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_individual_scorer.sv
// tb/tb_individual_scorer.sv - directed self-checking bench for individual_scorer
module tb_individual_scorer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid;
  logic [7:0]  vec_count;
  logic [15:0] y3, y2, y1, y0, e3, e2, e1, e0;
  logic        in_ready, busy, done;
  logic [15:0] score;
  logic [7:0]  perfect_cnt;

  logic         b_start, b_in_valid;
  logic [7:0]   b_vec;
  logic [255:0] b_y3, b_y2, b_y1, b_y0, b_e3, b_e2, b_e1, b_e0;
  logic         b_in_ready, b_busy, b_done;
  logic [15:0]  b_score;
  logic [7:0]   b_perfect_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int dcount, acc, iter, cyc, rc;
  logic tog;

  individual_scorer #(.W(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_count(vec_count),
    .in_valid(in_valid), .in_ready(in_ready),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .e3(e3), .e2(e2), .e1(e1), .e0(e0),
    .busy(busy), .done(done), .score(score), .perfect_cnt(perfect_cnt)
  );

  individual_scorer #(.W(256), .CW(8)) dut_wide (
    .clk(clk), .rst(rst), .start(b_start), .vec_count(b_vec),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .y3(b_y3), .y2(b_y2), .y1(b_y1), .y0(b_y0),
    .e3(b_e3), .e2(b_e2), .e1(b_e1), .e0(b_e0),
    .busy(b_busy), .done(b_done), .score(b_score), .perfect_cnt(b_perfect_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int maxc, output int c);
    c = 0;
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; vec_count = 8'd0;
    {y3, y2, y1, y0, e3, e2, e1, e0} = '0;
    b_start = 1'b0; b_in_valid = 1'b0; b_vec = 8'd0;
    {b_y3, b_y2, b_y1, b_y0, b_e3, b_e2, b_e1, b_e0} = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_perfect", 32'(perfect_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Perfect run, vec_count changed after the start cycle
    y3 = 16'hA5A5; e3 = 16'hA5A5; y2 = 16'h0001; e2 = 16'h0001;
    y1 = 16'hFFFF; e1 = 16'hFFFF; y0 = 16'h1234; e0 = 16'h1234;
    start = 1'b1; vec_count = 8'd3;
    @(negedge clk);
    start = 1'b0; vec_count = 8'd7;
    check("p_busy_run", 32'(busy), 32'd1);
    check("p_ready_run", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("p_ready_drop", 32'(in_ready), 32'd0);
    check("p_busy_drain", 32'(busy), 32'd1);
    check("p_done_t1", 32'(done), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("p_done_t2", 32'(done), 32'd0);
    check("p_score_t2", 32'(score), 32'd192);
    @(negedge clk);
    check("p_done_t3", 32'(done), 32'd1);
    check("p_busy_done", 32'(busy), 32'd0);
    check("p_score", 32'(score), 32'd192);
    check("p_perfect", 32'(perfect_cnt), 32'd3);
    @(negedge clk);
    check("p_done_pulse", 32'(done), 32'd0);
    check("p_score_hold", 32'(score), 32'd192);

    // All-wrong run
    {y3, y2, y1, y0} = {4{16'hFFFF}};
    {e3, e2, e1, e0} = '0;
    start = 1'b1; vec_count = 8'd2;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    in_valid = 1'b0;
    check("w_done_count", 32'(dcount), 32'd1);
    check("w_score", 32'(score), 32'd0);
    check("w_perfect", 32'(perfect_cnt), 32'd0);

    // Bubbles: 4 low bits differ per beat
    {y3, y2, y1} = {3{16'h3C3C}};
    {e3, e2, e1} = {3{16'h3C3C}};
    y0 = 16'h00F0; e0 = 16'h00FF;
    start = 1'b1; vec_count = 8'd4;
    @(negedge clk);
    start = 1'b0; acc = 0; tog = 1'b1; iter = 0;
    while (acc < 4 && iter < 40) begin
      in_valid = tog;
      if (tog && in_ready) acc++;
      tog = ~tog;
      @(negedge clk);
      iter++;
    end
    in_valid = 1'b0;
    check("b_loop_bound", 32'(iter < 40), 32'd1);
    check("b_ready_drop", 32'(in_ready), 32'd0);
    wait_done(20, cyc);
    check("b_done_seen", 32'(done), 32'd1);
    check("b_score", 32'(score), 32'd240);
    check("b_perfect", 32'(perfect_cnt), 32'd0);

    // Zero vectors
    @(negedge clk);
    start = 1'b1; vec_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("z_done", 32'(done), 32'd1);
    check("z_ready", 32'(in_ready), 32'd0);
    check("z_busy", 32'(busy), 32'd0);
    check("z_score", 32'(score), 32'd0);
    @(negedge clk);
    check("z_done_pulse", 32'(done), 32'd0);
    check("z_ready_after", 32'(in_ready), 32'd0);

    // Reset mid-run, then reset priority over start
    {y3, y2, y1, y0} = {4{16'h5A5A}};
    {e3, e2, e1, e0} = {4{16'h5A5A}};
    start = 1'b1; vec_count = 8'd5;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("r_pre_score", 32'(score), 32'd64);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("r_ready", 32'(in_ready), 32'd0);
    check("r_busy", 32'(busy), 32'd0);
    check("r_done", 32'(done), 32'd0);
    check("r_score", 32'(score), 32'd0);
    check("r_perfect", 32'(perfect_cnt), 32'd0);
    start = 1'b1; vec_count = 8'd3;
    @(negedge clk);
    check("r_prio_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0; dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("r_quiet", 32'(dcount), 32'd0);
    start = 1'b1; vec_count = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(10, cyc);
    check("r2_done_seen", 32'(done), 32'd1);
    check("r2_score", 32'(score), 32'd64);
    check("r2_perfect", 32'(perfect_cnt), 32'd1);

    // Saturation on the wide instance, start pulsed mid-run
    {b_y3, b_y2, b_y1, b_y0} = {32{32'hDEADBEEF}};
    {b_e3, b_e2, b_e1, b_e0} = {32{32'hDEADBEEF}};
    b_start = 1'b1; b_vec = 8'd255;
    @(negedge clk);
    b_start = 1'b0; b_in_valid = 1'b1; rc = 0; iter = 0;
    while (!b_done && iter < 400) begin
      if (b_in_ready) rc++;
      b_start = (iter == 10);
      @(negedge clk);
      iter++;
    end
    b_start = 1'b0; b_in_valid = 1'b0;
    check("s_done_seen", 32'(b_done), 32'd1);
    check("s_run_len", 32'(rc), 32'd255);
    check("s_score", 32'(b_score), 32'h0000FFFF);
    check("s_perfect", 32'(b_perfect_cnt), 32'd255);
    @(negedge clk);
    check("s_idle_busy", 32'(b_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
